// File: rtl/alu_operand_collector.sv
// -----------------------------------------------------------------------------
// alu_operand_collector
//
// Gathers the operands for one ALU operation, possibly spread over several
// upstream beats. The first beat fixes mode/cmd/cin and therefore which
// operands are needed. Once every needed operand has been seen, the operation
// is issued to the ALU for one cycle. If the missing operands do not arrive
// within TIMEOUT collect cycles, the transaction is dropped and timeout_err
// pulses.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ce                clock enable; ce=0 freezes everything
//   in_valid/in_ready upstream handshake (accept = in_valid & in_ready)
//   in_inp_valid      bit0 = in_opa present, bit1 = in_opb present
//   in_opa, in_opb    operand data
//   in_mode, in_cmd,  command fields (used from the first beat only)
//   in_cin
//   opa, opb, mode,   registered operation presented to the ALU
//   cmd, cin
//   inp_valid         operand mask, nonzero only while issuing
//   out_valid         issue strobe
//   timeout_err       pulse when a partial transaction is dropped
// -----------------------------------------------------------------------------
module alu_operand_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_inp_valid,
   input  logic [DATA_WIDTH-1:0] in_opa,
   input  logic [DATA_WIDTH-1:0] in_opb,
   input  logic                  in_mode,
   input  logic [CMD_WIDTH-1:0]  in_cmd,
   input  logic                  in_cin,
   output logic [DATA_WIDTH-1:0] opa,
   output logic [DATA_WIDTH-1:0] opb,
   output logic                  mode,
   output logic [CMD_WIDTH-1:0]  cmd,
   output logic                  cin,
   output logic [1:0]            inp_valid,
   output logic                  out_valid,
   output logic                  timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      ISSUE
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [1:0]            r_gathered;
   logic [1:0]            r_req;
   logic [DATA_WIDTH-1:0] r_opaHold;
   logic [DATA_WIDTH-1:0] r_opbHold;
   logic                  r_modeHold;
   logic [CMD_WIDTH-1:0]  r_cmdHold;
   logic                  r_cinHold;

   logic [DATA_WIDTH-1:0] r_opa;
   logic [DATA_WIDTH-1:0] r_opb;
   logic                  r_mode;
   logic [CMD_WIDTH-1:0]  r_cmd;
   logic                  r_cin;
   logic [1:0]            r_inpValid;
   logic                  r_outValid;
   logic                  r_timeoutErr;

   logic                  w_accept;
   logic                  w_start;
   logic [1:0]            w_req;
   logic [1:0]            w_nextHave;
   logic [DATA_WIDTH-1:0] w_nextOpa;
   logic [DATA_WIDTH-1:0] w_nextOpb;
   logic                  w_mode;
   logic [CMD_WIDTH-1:0]  w_cmd;
   logic                  w_cin;
   logic                  w_done;

   // Operands the command actually consumes; unknown codes need nothing,
   // so any non-empty beat completes them immediately.
   function automatic logic [1:0] reqMask(input logic m, input logic [CMD_WIDTH-1:0] c);
      int unsigned code;
      code = 32'(c);
      if (m) begin
         if (code inside {4, 5})                   return 2'b01;
         if (code inside {6, 7})                   return 2'b10;
         if (code inside {[0:3], [8:10]})          return 2'b11;
      end else begin
         if (code inside {6, 8, 9})                return 2'b01;
         if (code inside {7, 10, 11})              return 2'b10;
         if (code inside {[0:5], 12, 13})          return 2'b11;
      end
      return 2'b00;
   endfunction

   // in_ready already folds in ce and the ISSUE stall, so w_accept is the
   // full handshake.
   assign in_ready = ce & (r_state != ISSUE);
   assign w_accept = in_valid & in_ready;
   assign w_start  = w_accept & (r_state == IDLE) & (in_inp_valid != 2'b00);

   // View of the transaction after merging the current beat. In IDLE the
   // beat starts from scratch (absent operands read as zero); in COLLECT it
   // overlays the held copy.
   assign w_req      = (r_state == IDLE) ? reqMask(in_mode, in_cmd) : r_req;
   assign w_nextHave = ((r_state == IDLE) ? 2'b00 : r_gathered) | (w_accept ? in_inp_valid : 2'b00);
   assign w_nextOpa  = (w_accept & in_inp_valid[0]) ? in_opa : ((r_state == IDLE) ? '0 : r_opaHold);
   assign w_nextOpb  = (w_accept & in_inp_valid[1]) ? in_opb : ((r_state == IDLE) ? '0 : r_opbHold);
   assign w_mode     = (r_state == IDLE) ? in_mode : r_modeHold;
   assign w_cmd      = (r_state == IDLE) ? in_cmd  : r_cmdHold;
   assign w_cin      = (r_state == IDLE) ? in_cin  : r_cinHold;
   assign w_done     = ((w_nextHave & w_req) == w_req);

   // Collector FSM. A completing beat is checked before the timeout so that
   // an operand arriving on the last allowed cycle still issues. The ALU-side
   // registers load only on entry to ISSUE and otherwise keep the last
   // issued operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_gathered   <= 2'b00;
         r_req        <= 2'b00;
         r_opaHold    <= '0;
         r_opbHold    <= '0;
         r_modeHold   <= 1'b0;
         r_cmdHold    <= '0;
         r_cinHold    <= 1'b0;
         r_opa        <= '0;
         r_opb        <= '0;
         r_mode       <= 1'b0;
         r_cmd        <= '0;
         r_cin        <= 1'b0;
         r_inpValid   <= 2'b00;
         r_outValid   <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else if (ce) begin
         r_timeoutErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_gathered <= w_nextHave;
                  r_req      <= w_req;
                  r_opaHold  <= w_nextOpa;
                  r_opbHold  <= w_nextOpb;
                  r_modeHold <= w_mode;
                  r_cmdHold  <= w_cmd;
                  r_cinHold  <= w_cin;
                  if (w_done) begin
                     r_state    <= ISSUE;
                     r_outValid <= 1'b1;
                     r_inpValid <= w_nextHave;
                     r_opa      <= w_nextOpa;
                     r_opb      <= w_nextOpb;
                     r_mode     <= w_mode;
                     r_cmd      <= w_cmd;
                     r_cin      <= w_cin;
                  end else begin
                     r_state <= COLLECT;
                     r_cnt   <= CNT_ONE;
                  end
               end
            end
            COLLECT: begin
               r_gathered <= w_nextHave;
               r_opaHold  <= w_nextOpa;
               r_opbHold  <= w_nextOpb;
               if (w_done) begin
                  r_state    <= ISSUE;
                  r_cnt      <= '0;
                  r_outValid <= 1'b1;
                  r_inpValid <= w_nextHave;
                  r_opa      <= w_nextOpa;
                  r_opb      <= w_nextOpb;
                  r_mode     <= w_mode;
                  r_cmd      <= w_cmd;
                  r_cin      <= w_cin;
               end else if (r_cnt == TIMEOUT_CNT) begin
                  r_state      <= IDLE;
                  r_cnt        <= '0;
                  r_gathered   <= 2'b00;
                  r_opaHold    <= '0;
                  r_opbHold    <= '0;
                  r_timeoutErr <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ISSUE: begin
               r_state    <= IDLE;
               r_gathered <= 2'b00;
               r_outValid <= 1'b0;
               r_inpValid <= 2'b00;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign opa         = r_opa;
   assign opb         = r_opb;
   assign mode        = r_mode;
   assign cmd         = r_cmd;
   assign cin         = r_cin;
   assign inp_valid   = r_inpValid;
   assign out_valid   = r_outValid;
   assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_alu_operand_collector.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_collector
//
// Self-checking bench for alu_operand_collector: a table of single-beat
// vectors, hand-written multi-cycle sequences, and a randomized run compared
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_operand_collector;

   localparam int DW = 8;
   localparam int CW = 4;
   localparam int TO = 16;

   logic          clk;
   logic          rst;
   logic          ce;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_inp_valid;
   logic [DW-1:0] in_opa;
   logic [DW-1:0] in_opb;
   logic          in_mode;
   logic [CW-1:0] in_cmd;
   logic          in_cin;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic          mode;
   logic [CW-1:0] cmd;
   logic          cin;
   logic [1:0]    inp_valid;
   logic          out_valid;
   logic          timeout_err;

   int vectorCount = 0;
   int missCount   = 0;

   alu_operand_collector #(
      .DATA_WIDTH (DW),
      .CMD_WIDTH  (CW),
      .TIMEOUT    (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inp_valid (in_inp_valid),
      .in_opa       (in_opa),
      .in_opb       (in_opb),
      .in_mode      (in_mode),
      .in_cmd       (in_cmd),
      .in_cin       (in_cin),
      .opa          (opa),
      .opb          (opb),
      .mode         (mode),
      .cmd          (cmd),
      .cin          (cin),
      .inp_valid    (inp_valid),
      .out_valid    (out_valid),
      .timeout_err  (timeout_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-beat vector: inputs plus the expected issue result one cycle later
   typedef struct {
      logic       mode;
      logic [3:0] cmd;
      logic [1:0] inp;
      logic [7:0] a;
      logic [7:0] b;
      logic       expValid;
      logic [1:0] expInp;
      logic [7:0] expA;
      logic [7:0] expB;
   } vec_t;

   vec_t tbl [14];

   // Reference model state: one pending transaction, counted in ce cycles
   bit         mIssuing;
   bit         mActive;
   bit [1:0]   mNeed;
   bit [1:0]   mHave;
   logic [7:0] mA;
   logic [7:0] mB;
   logic       mMode;
   logic [3:0] mCmd;
   logic       mCin;
   int         ceIndex;
   int         mStart;
   logic       eValid;
   logic       eErr;
   logic [1:0] eInp;
   logic       eCin;
   logic       eMode;
   logic [3:0] eCmd;
   logic [7:0] eA;
   logic [7:0] eB;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] iv, input logic [7:0] a,
                                input logic [7:0] b, input logic m, input logic [3:0] cm,
                                input logic ci);
      in_valid     = v;
      in_inp_valid = iv;
      in_opa       = a;
      in_opb       = b;
      in_mode      = m;
      in_cmd       = cm;
      in_cin       = ci;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   function automatic logic [25:0] dutPack();
      return {out_valid, timeout_err, inp_valid, cin, mode, cmd, opa, opb};
   endfunction

   function automatic logic [25:0] modelPack();
      return {eValid, eErr, eInp, eCin, eMode, eCmd, eA, eB};
   endfunction

   task automatic idle();
      applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   // Operands a command consumes, listed straight from the command table
   function automatic logic [1:0] needOf(input logic m, input logic [3:0] c);
      int k;
      k = 32'(c);
      if (m == 1'b1) begin
         if (k == 4 || k == 5) return 2'b01;
         if (k == 6 || k == 7) return 2'b10;
         if ((k >= 0 && k <= 3) || (k >= 8 && k <= 10)) return 2'b11;
      end else begin
         if (k == 6 || k == 8 || k == 9) return 2'b01;
         if (k == 7 || k == 10 || k == 11) return 2'b10;
         if ((k >= 0 && k <= 5) || k == 12 || k == 13) return 2'b11;
      end
      return 2'b00;
   endfunction

   task automatic modelReset();
      mIssuing = 0; mActive = 0; mNeed = 0; mHave = 0;
      mA = 0; mB = 0; mMode = 0; mCmd = 0; mCin = 0;
      ceIndex = 0; mStart = 0;
      eValid = 0; eErr = 0; eInp = 0; eCin = 0; eMode = 0; eCmd = 0; eA = 0; eB = 0;
   endtask

   // Advance the model by one clock edge with the given inputs
   task automatic modelStep(input logic r, input logic c, input logic v, input logic [1:0] iv,
                            input logic [7:0] a, input logic [7:0] b, input logic m,
                            input logic [3:0] cm, input logic ci);
      if (r) begin
         modelReset();
         return;
      end
      if (!c) return;
      ceIndex++;
      eErr = 0;
      if (mIssuing) begin
         mIssuing = 0;
         eValid   = 0;
         eInp     = 0;
         return;
      end
      if (!mActive) begin
         if (v && iv != 2'b00) begin
            mActive = 1;
            mNeed   = needOf(m, cm);
            mHave   = iv;
            mA      = iv[0] ? a : 8'h00;
            mB      = iv[1] ? b : 8'h00;
            mMode   = m;
            mCmd    = cm;
            mCin    = ci;
            mStart  = ceIndex;
         end
      end else if (v) begin
         if (iv[0]) mA = a;
         if (iv[1]) mB = b;
         mHave = mHave | iv;
      end
      if (mActive) begin
         if ((mHave & mNeed) == mNeed) begin
            mActive  = 0;
            mIssuing = 1;
            eValid   = 1;
            eInp     = mHave;
            eA       = mA;
            eB       = mB;
            eMode    = mMode;
            eCmd     = mCmd;
            eCin     = mCin;
         end else if (ceIndex - mStart == TO) begin
            mActive = 0;
            eErr    = 1;
         end
      end
   endtask

   initial begin
      int errAt;
      int errCnt;
      int validSeen;
      logic       rr, rc, rv, rm, rci;
      logic [1:0] riv;
      logic [7:0] ra, rb;
      logic [3:0] rcm;

      tbl[0]  = '{1'b1, 4'd0,  2'b11, 8'h12, 8'h34, 1'b1, 2'b11, 8'h12, 8'h34};
      tbl[1]  = '{1'b1, 4'd4,  2'b01, 8'hA5, 8'h77, 1'b1, 2'b01, 8'hA5, 8'h00};
      tbl[2]  = '{1'b1, 4'd6,  2'b10, 8'h11, 8'h22, 1'b1, 2'b10, 8'h00, 8'h22};
      tbl[3]  = '{1'b1, 4'd9,  2'b01, 8'h5A, 8'h66, 1'b0, 2'b00, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 4'd8,  2'b01, 8'hC3, 8'h99, 1'b1, 2'b01, 8'hC3, 8'h00};
      tbl[5]  = '{1'b0, 4'd11, 2'b10, 8'h44, 8'hE7, 1'b1, 2'b10, 8'h00, 8'hE7};
      tbl[6]  = '{1'b0, 4'd12, 2'b10, 8'h01, 8'h02, 1'b0, 2'b00, 8'h00, 8'h00};
      tbl[7]  = '{1'b1, 4'd12, 2'b01, 8'h80, 8'h08, 1'b1, 2'b01, 8'h80, 8'h00};
      tbl[8]  = '{1'b0, 4'd15, 2'b10, 8'hF0, 8'h0F, 1'b1, 2'b10, 8'h00, 8'h0F};
      tbl[9]  = '{1'b1, 4'd5,  2'b11, 8'h3C, 8'hC3, 1'b1, 2'b11, 8'h3C, 8'hC3};
      tbl[10] = '{1'b1, 4'd0,  2'b00, 8'hAA, 8'hBB, 1'b0, 2'b00, 8'h00, 8'h00};
      tbl[11] = '{1'b0, 4'd7,  2'b11, 8'h0A, 8'h0B, 1'b1, 2'b11, 8'h0A, 8'h0B};
      tbl[12] = '{1'b1, 4'd10, 2'b01, 8'h5F, 8'h60, 1'b0, 2'b00, 8'h00, 8'h00};
      tbl[13] = '{1'b0, 4'd13, 2'b10, 8'h71, 8'h72, 1'b0, 2'b00, 8'h00, 8'h00};

      rst = 1'b1;
      ce  = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_outputs", dutPack(), 26'h0);
      checkOutput("reset_ready", in_ready, 1'b1);

      // Table: one beat from a freshly reset collector, cin driven high
      foreach (tbl[i]) begin
         doReset();
         applyStimulus(1'b1, tbl[i].inp, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].cmd, 1'b1);
         tick();
         idle();
         checkOutput($sformatf("tbl%0d", i), dutPack(),
                     {tbl[i].expValid, 1'b0, tbl[i].expInp, tbl[i].expValid,
                      tbl[i].expValid ? tbl[i].mode : 1'b0,
                      tbl[i].expValid ? tbl[i].cmd : 4'h0, tbl[i].expA, tbl[i].expB});
      end

      // Two-beat logical op, second beat three edges after the first
      doReset();
      applyStimulus(1'b1, 2'b01, 8'hA5, 8'hEE, 1'b0, 4'd12, 1'b1);
      tick();
      idle();
      checkOutput("s2_waiting", out_valid, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 2'b10, 8'h99, 8'h03, 1'b1, 4'd3, 1'b0);
      tick();
      idle();
      checkOutput("s2_issue", dutPack(), {1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 4'd12, 8'hA5, 8'h03});
      tick();
      checkOutput("s2_hold", dutPack(), {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'd12, 8'hA5, 8'h03});

      // Missing operand never arrives
      doReset();
      applyStimulus(1'b1, 2'b01, 8'h5A, 8'h00, 1'b1, 4'd9, 1'b0);
      tick();
      idle();
      errAt = -1;
      errCnt = 0;
      validSeen = 0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (timeout_err) begin
            errCnt++;
            if (errAt < 0) errAt = k;
         end
         if (out_valid) validSeen++;
      end
      checkOutput("s3_err_cycle", errAt, 16);
      checkOutput("s3_err_count", errCnt, 1);
      checkOutput("s3_no_issue", validSeen, 0);
      checkOutput("s3_ready", in_ready, 1'b1);

      // Missing operand arrives on the last allowed cycle
      doReset();
      applyStimulus(1'b1, 2'b01, 8'h21, 8'h00, 1'b1, 4'd9, 1'b0);
      tick();
      idle();
      repeat (15) tick();
      checkOutput("s4_waiting", {out_valid, timeout_err}, 2'b00);
      applyStimulus(1'b1, 2'b10, 8'hFF, 8'h43, 1'b0, 4'd0, 1'b1);
      tick();
      idle();
      checkOutput("s4_issue", dutPack(), {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 4'd9, 8'h21, 8'h43});
      tick();
      checkOutput("s4_after", dutPack(), {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd9, 8'h21, 8'h43});

      // Immediate single-operand issue, then stalled by ce=0
      doReset();
      applyStimulus(1'b1, 2'b01, 8'h3C, 8'h77, 1'b1, 4'd4, 1'b1);
      tick();
      checkOutput("s5_issue", dutPack(), {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'd4, 8'h3C, 8'h00});
      ce = 1'b0;
      applyStimulus(1'b1, 2'b11, 8'hDE, 8'hAD, 1'b0, 4'd1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("s5_frozen%0d", k), {dutPack(), in_ready},
                     {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'd4, 8'h3C, 8'h00, 1'b0});
      end
      ce = 1'b1;
      idle();
      #1;
      checkOutput("s5_ready_in_issue", in_ready, 1'b0);
      tick();
      checkOutput("s5_release", dutPack(), {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'd4, 8'h3C, 8'h00});

      // Reset in the middle of a collection
      applyStimulus(1'b1, 2'b01, 8'h11, 8'h00, 1'b0, 4'd12, 1'b1);
      tick();
      idle();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("s6_reset", {dutPack(), in_ready}, {26'h0, 1'b1});
      applyStimulus(1'b1, 2'b11, 8'hAA, 8'hBB, 1'b1, 4'd0, 1'b0);
      tick();
      idle();
      checkOutput("s6_fresh", dutPack(), {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 4'd0, 8'hAA, 8'hBB});

      // Randomized run against the reference model; alternating dense and
      // sparse beat phases so timeouts also occur
      doReset();
      modelReset();
      for (int i = 0; i < 600; i++) begin
         rr  = ($urandom_range(0, 149) == 0);
         rc  = ($urandom_range(0, 7) != 0);
         rv  = (((i / 100) % 2) == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
         riv = 2'($urandom);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rm  = ($urandom_range(0, 1) == 1);
         rcm = 4'($urandom);
         rci = ($urandom_range(0, 1) == 1);
         rst = rr;
         ce  = rc;
         applyStimulus(rv, riv, ra, rb, rm, rcm, rci);
         #1;
         checkOutput("rand_ready", in_ready, rc && !mIssuing);
         modelStep(rr, rc, rv, riv, ra, rb, rm, rcm, rci);
         tick();
         checkOutput($sformatf("rand_out%0d", i), dutPack(), modelPack());
      end
      rst = 1'b0;
      ce  = 1'b1;
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, operand width; CMD_WIDTH, 4, command width; TIMEOUT, 16, max cycles to wait for a missing operand.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- ce  in  1  clock enable
- in_valid  in  1  upstream beat valid
- in_ready  out  1  beat accepted when in_valid and in_ready and ce
- in_inp_valid  in  2  bit0 = in_opa present, bit1 = in_opb present
- in_opa  in  DATA_WIDTH  operand A
- in_opb  in  DATA_WIDTH  operand B
- in_mode  in  1  1 = arithmetic, 0 = logical
- in_cmd  in  CMD_WIDTH  command
- in_cin  in  1  carry in
- opa, opb  out  DATA_WIDTH  operands to ALU
- mode, cmd, cin  out  1/CMD_WIDTH/1  to ALU
- inp_valid  out  2  operand mask to ALU
- out_valid  out  1  one-cycle issue strobe
- timeout_err  out  1  one-cycle pulse, transaction dropped

Function
REQ-004 Required mask SHALL decode from the first beat's mode/cmd:
- mode=1: cmds 4,5 -> 01; cmds 6,7 -> 10; cmds 0-3, 8-10 -> 11.
- mode=0: cmds 6,8,9 -> 01; cmds 7,10,11 -> 10; cmds 0-5, 12, 13 -> 11.
- Any other code -> 00.
REQ-005 The FSM SHALL have states IDLE, COLLECT and ISSUE.
REQ-006 in_ready SHALL be 1 in IDLE and COLLECT with ce=1, and 0 in ISSUE or when ce=0.
REQ-007 IDLE: an accepted beat with in_inp_valid=00 SHALL be ignored.
REQ-008 IDLE: on any other accepted beat, the block SHALL latch mode/cmd/cin and the present operands, and set gathered = in_inp_valid.
REQ-009 IDLE: if gathered covers the required mask, the next state SHALL be ISSUE; otherwise it SHALL be COLLECT with cnt=1.
REQ-010 COLLECT: an accepted beat SHALL merge only its present operands into gathered, overwriting any held copy; its mode/cmd/cin SHALL be ignored.
REQ-011 COLLECT: when gathered covers the required mask, the next state SHALL be ISSUE.
REQ-012 COLLECT: each ce cycle without completion SHALL increment cnt.
REQ-013 COLLECT: when cnt==TIMEOUT and no completing beat arrives, the block SHALL go to IDLE, discard the operands and pulse timeout_err for one cycle.
REQ-014 A completing beat in the same cycle as the timeout condition SHALL win: issue, no timeout_err.
REQ-015 ISSUE (one cycle): out_valid=1, inp_valid=gathered, and opa/opb/mode/cmd/cin SHALL present the collected values.
REQ-016 ISSUE SHALL return to IDLE on the next ce cycle.
REQ-017 Latency SHALL be: a complete single beat accepted at edge N gives out_valid high in the cycle after edge N.
REQ-018 Outside ISSUE, out_valid=0 and inp_valid=00; opa/opb/mode/cmd/cin SHALL hold their last issued values.
REQ-019 ce=0 SHALL freeze state, cnt and all outputs.
REQ-020 In ISSUE with ce=0, out_valid SHALL remain high until a ce cycle is consumed.
REQ-021 An absent operand SHALL issue as 0 in opa/opb.
REQ-022 All outputs SHALL be registered except in_ready.

Reset
REQ-023 rst=1 at a clk edge SHALL force IDLE, cnt=0 and gathered=00.
REQ-024 rst=1 SHALL force opa, opb, cmd, mode, cin, inp_valid, out_valid and timeout_err to 0.
REQ-025 rst SHALL take priority over ce and over any beat in the same cycle.
REQ-026 rst mid-COLLECT SHALL drop the partial transaction with no out_valid and no timeout_err.

Verification
REQ-027 Scenario 1: mode=1, cmd=0, opa=0x12, opb=0x34, in_inp_valid=11 -> next cycle out_valid=1, inp_valid=11, opa=0x12, opb=0x34.
REQ-028 Scenario 2: mode=0, cmd=12, beat in_inp_valid=01 opa=0xA5, then 3 cycles later a beat with 10 opb=0x03 -> out_valid one cycle after the second beat, inp_valid=11, opa=0xA5, opb=0x03, cmd=12.
REQ-029 Scenario 3: mode=1, cmd=9, beat with 01 only, no further beats -> timeout_err=1 for exactly one cycle after 16 COLLECT cycles, out_valid never 1, in_ready high afterwards.
REQ-030 Scenario 4: missing operand arrives in the same cycle cnt==16 -> out_valid=1, timeout_err=0.
REQ-031 Scenario 5: mode=1, cmd=4 with 01 -> immediate issue with inp_valid=01 and opb=0. ce=0 held 5 cycles during ISSUE -> outputs stable and out_valid high until ce returns.
REQ-032 Scenario 6: rst=1 during COLLECT -> next cycle all outputs 0 and in_ready=1. A fresh two-operand beat then issues normally.
